// File: rtl/debounce_bank.sv
// Multi-channel input conditioner: per-bit 2-flop synchroniser, stability counter,
// registered edge pulses for buttons and switches, and button auto-repeat.
module debounce_bank #(
    parameter int BTN_N      = 4,
    parameter int SW_N       = 8,
    parameter int STABLE_CYC = 100000,
    parameter int REPEAT_DLY = 50000000,
    parameter int REPEAT_PER = 10000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BTN_N-1:0]  button,
    input  logic [SW_N-1:0]   SW,
    output logic [BTN_N-1:0]  btn_level,
    output logic [BTN_N-1:0]  btn_press,
    output logic [BTN_N-1:0]  btn_release,
    output logic [BTN_N-1:0]  btn_repeat,
    output logic [SW_N-1:0]   sw_level,
    output logic [SW_N-1:0]   sw_change
);

    localparam int N  = BTN_N + SW_N;
    localparam int CW = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(STABLE_CYC - 1);

    // Buttons occupy the low bits, switches the high bits of every per-channel vector.
    logic [N-1:0]  raw;
    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  level;
    logic [N-1:0]  flip;
    logic [CW-1:0] cnt [N];

    assign raw = {SW, button};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_comb begin
        flip = '0;
        for (int i = 0; i < N; i++) begin
            flip[i] = (s2[i] != level[i]) && (cnt[i] == CNT_TC);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            level <= level ^ flip;
            for (int i = 0; i < N; i++) begin
                if ((s2[i] == level[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Pulses register on the same edge as the level, so both appear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_press   <= '0;
            btn_release <= '0;
            sw_change   <= '0;
        end else begin
            btn_press   <= flip[BTN_N-1:0] &  s2[BTN_N-1:0];
            btn_release <= flip[BTN_N-1:0] & ~s2[BTN_N-1:0];
            sw_change   <= flip[N-1:BTN_N];
        end
    end

    assign btn_level = level[BTN_N-1:0];
    assign sw_level  = level[N-1:BTN_N];

    generate
        if (REPEAT_DLY > 0) begin : g_repeat
            localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
            localparam int RW   = $clog2(RMAX + 1);
            localparam logic [RW-1:0] DLY_LD = RW'(REPEAT_DLY - 1);
            localparam logic [RW-1:0] PER_LD = RW'(REPEAT_PER - 1);

            logic [RW-1:0] rep_cnt [BTN_N];

            // Down-counter per button: loaded on press, fires at zero, reloads with the period.
            // A falling flip lands in the clear branch, so no pulse can meet the release.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    btn_repeat <= '0;
                    for (int i = 0; i < BTN_N; i++) begin
                        rep_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < BTN_N; i++) begin
                        if (flip[i] && s2[i]) begin
                            rep_cnt[i]    <= DLY_LD;
                            btn_repeat[i] <= 1'b0;
                        end else if (level[i] && !flip[i]) begin
                            if (rep_cnt[i] == '0) begin
                                rep_cnt[i]    <= PER_LD;
                                btn_repeat[i] <= 1'b1;
                            end else begin
                                rep_cnt[i]    <= rep_cnt[i] - RW'(1);
                                btn_repeat[i] <= 1'b0;
                            end
                        end else begin
                            rep_cnt[i]    <= '0;
                            btn_repeat[i] <= 1'b0;
                        end
                    end
                end
            end
        end else begin : g_no_repeat
            assign btn_repeat = '0;
        end
    endgenerate

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: directed scenarios plus randomized bounce traffic,
// every cycle compared against a sliding-window behavioural model.
module tb_debounce_bank;

    localparam int BTN_N = 4;
    localparam int SW_N  = 8;
    localparam int N     = BTN_N + SW_N;
    localparam int SC    = 4;
    localparam int DLY   = 10;
    localparam int PER   = 3;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [BTN_N-1:0] button = '0;
    logic [SW_N-1:0]  sw     = '0;
    logic [BTN_N-1:0] btn_level, btn_press, btn_release, btn_repeat;
    logic [SW_N-1:0]  sw_level, sw_change;

    debounce_bank #(
        .BTN_N(BTN_N), .SW_N(SW_N), .STABLE_CYC(SC),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .SW(sw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .btn_repeat(btn_repeat), .sw_level(sw_level), .sw_change(sw_change)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: level flips once the last SC synchronised samples all
    // disagree with it; repeats follow from elapsed time since the press.
    logic [N-1:0]     m_r1 = '0, m_r2 = '0, m_level = '0, m_fl = '0;
    logic [BTN_N-1:0] e_press = '0, e_rel = '0, e_rep = '0;
    logic [SW_N-1:0]  e_chg = '0;
    bit               win [N][$];
    int               t_press [BTN_N];
    int               edge_no = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_r1 = '0; m_r2 = '0; m_level = '0; m_fl = '0;
                e_press = '0; e_rel = '0; e_rep = '0; e_chg = '0;
                for (int ch = 0; ch < N; ch++) win[ch].delete();
            end else begin
                for (int ch = 0; ch < N; ch++) begin
                    win[ch].push_back(m_r2[ch]);
                    if (win[ch].size() > SC) void'(win[ch].pop_front());
                    m_fl[ch] = (win[ch].size() == SC);
                    for (int j = 0; j < win[ch].size(); j++)
                        if (win[ch][j] == m_level[ch]) m_fl[ch] = 1'b0;
                end
                for (int b = 0; b < BTN_N; b++) begin
                    e_press[b] = m_fl[b] & ~m_level[b];
                    e_rel[b]   = m_fl[b] &  m_level[b];
                    if (e_press[b]) t_press[b] = edge_no;
                    e_rep[b] = m_level[b] && !m_fl[b] && (edge_no - t_press[b] >= DLY)
                               && ((edge_no - t_press[b] - DLY) % PER == 0);
                end
                e_chg   = m_fl[N-1:BTN_N];
                m_level = m_level ^ m_fl;
                m_r2    = m_r1;
                m_r1    = {sw, button};
            end
            edge_no++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("btn_level",   32'(btn_level),   32'(m_level[BTN_N-1:0]));
            chk("sw_level",    32'(sw_level),    32'(m_level[N-1:BTN_N]));
            chk("btn_press",   32'(btn_press),   32'(e_press));
            chk("btn_release", 32'(btn_release), 32'(e_rel));
            chk("btn_repeat",  32'(btn_repeat),  32'(e_rep));
            chk("sw_change",   32'(sw_change),   32'(e_chg));
        end
    end

    // Counts edges until btn_press[b]; -1 if it never comes.
    task automatic wait_press(input int b, output int n);
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (btn_press[b]) begin
                n = k;
                return;
            end
        end
    endtask

    int n, reps, first_rep, last_rep, rel_k, seen;
    int base [N];
    int gl   [N];
    logic [N-1:0] v;

    initial begin
        // Reset with button[0] held
        button = 4'b0001;
        repeat (3) @(negedge clk);
        chk("rst_outputs", 32'({btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change}), 32'h0);
        rst_n = 1'b1;
        wait_press(0, n);
        chk("rst_press_lat", 32'(n), 32'd6);
        chk("rst_press_only0", 32'(btn_press), 32'h1);
        @(posedge clk); #1;
        chk("rst_press_width", 32'(btn_press[0]), 32'h0);
        @(negedge clk); button = '0;
        repeat (12) @(negedge clk);

        // Bounce on button[1]
        button[1] = 1'b1; @(negedge clk);
        button[1] = 1'b0; @(negedge clk);
        button[1] = 1'b1; @(negedge clk);
        button[1] = 1'b1; @(negedge clk);
        button[1] = 1'b0; @(negedge clk);
        button[1] = 1'b1;
        wait_press(1, n);
        chk("bounce_press_lat", 32'(n), 32'd6);
        @(negedge clk); button = '0;
        repeat (12) @(negedge clk);

        // Hold button[2] and check repeat cadence and release
        button[2] = 1'b1;
        wait_press(2, n);
        chk("hold_press_lat", 32'(n), 32'd6);
        reps = 0; first_rep = -1; last_rep = -1; rel_k = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge clk); #1;
            if (btn_repeat[2]) begin
                reps++;
                if (first_rep < 0) first_rep = k;
                last_rep = k;
            end
            if (btn_release[2]) rel_k = k;
            if (k == 24) button[2] = 1'b0;
        end
        chk("hold_rep_count", 32'(reps), 32'd7);
        chk("hold_rep_first", 32'(first_rep), 32'd10);
        chk("hold_rep_last", 32'(last_rep), 32'd28);
        chk("hold_release_at", 32'(rel_k), 32'd30);
        repeat (5) @(negedge clk);

        // Simultaneous transitions on many channels
        button = 4'hF; sw = 8'hA5;
        n = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (|btn_press) begin
                n = k;
                break;
            end
        end
        chk("simul_lat", 32'(n), 32'd6);
        chk("simul_press", 32'(btn_press), 32'hF);
        chk("simul_change", 32'(sw_change), 32'hA5);
        @(negedge clk); button = '0; sw = '0;
        repeat (12) @(negedge clk);

        // Reset during repeat phase of button[3]
        button[3] = 1'b1;
        seen = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (btn_repeat[3]) begin
                seen = 1;
                break;
            end
        end
        chk("rr_repeat_seen", 32'(seen), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("rr_async_clear", 32'({btn_level, btn_press, btn_release, btn_repeat, sw_level, sw_change}), 32'h0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        wait_press(3, n);
        chk("rr_fresh_press_lat", 32'(n), 32'd6);

        // Randomized bouncing traffic on every channel
        for (int ch = 0; ch < N; ch++) begin
            base[ch] = (ch == 3) ? 1 : 0;
            gl[ch]   = 0;
        end
        repeat (3000) begin
            @(negedge clk);
            for (int ch = 0; ch < N; ch++) begin
                if (gl[ch] > 0) gl[ch]--;
                else if ($urandom_range(0, 39) == 0) base[ch] = 1 - base[ch];
                else if ($urandom_range(0, 24) == 0) gl[ch] = $urandom_range(1, 6);
                v[ch] = (gl[ch] > 0) ? ~base[ch][0] : base[ch][0];
            end
            {sw, button} = v;
        end
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel input conditioner for board push-buttons and slide switches. Each channel has its own synchroniser and stability counter, so a bouncing input never delays qualification of another channel. Buttons produce debounced levels plus one-cycle press, release and auto-repeat pulses; switches produce debounced levels plus a one-cycle change pulse. The block sits between the board I/O pins and the control logic or display datapath.

## Interface
- BTN_N, 4, number of button channels (≥1)
- SW_N, 8, number of switch channels (≥1)
- STABLE_CYC, 100000, consecutive cycles a synchronised input must differ from the debounced level before the level is updated (≥1)
- REPEAT_DLY, 50000000, cycles from press until the first auto-repeat pulse; 0 disables auto-repeat
- REPEAT_PER, 10000000, cycles between later auto-repeat pulses (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- button  in  BTN_N  raw button pins, active-high
- SW  in  SW_N  raw switch pins
- btn_level  out  BTN_N  debounced button levels
- btn_press  out  BTN_N  one-cycle pulse on a debounced 0→1 transition
- btn_release  out  BTN_N  one-cycle pulse on a debounced 1→0 transition
- btn_repeat  out  BTN_N  auto-repeat pulses while a button is held
- sw_level  out  SW_N  debounced switch levels
- sw_change  out  SW_N  one-cycle pulse on any debounced switch transition

Reset is asynchronous and active-low, with one clock.

## Operation
- Every input bit goes through a 2-flop synchroniser (s1→s2). Nothing else samples the raw pins.
- Per channel: stability counter cnt, sized internally as $clog2(STABLE_CYC+1) bits.
  - If s2 equals the debounced level, cnt is cleared to 0.
  - Otherwise cnt increments. On the edge where cnt == STABLE_CYC-1, the level takes the value of s2 and cnt is cleared.
  - A glitch shorter than STABLE_CYC synchronised cycles never changes the level. Any return to the current level restarts the count from 0.
- Edge pulses are registered. btn_press, btn_release and sw_change are high for exactly the first cycle in which the new level is visible.
- Auto-repeat, per button, applies only when REPEAT_DLY > 0:
  - hold counter is set to 0 on the press edge and increments every cycle while the level is 1.
  - When hold reaches REPEAT_DLY, btn_repeat pulses for one cycle and hold reloads to REPEAT_DLY-REPEAT_PER. Pulses then follow every REPEAT_PER cycles.
  - Release clears hold immediately. No repeat pulse may occur on or after the release cycle.
  - btn_press never coincides with btn_repeat.
  - Counter widths come from max(REPEAT_DLY, REPEAT_PER). Counters must not wrap.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.

## Timing
- Reset values: every output is 0. Synchronisers, levels, cnt and hold are all 0.
- After rst_n deasserts, a pin held high is treated as a normal 0→1 transition. It produces press or sw_change after the full latency.
- Assertion of rst_n mid-count or mid-hold aborts immediately. No pulse is emitted.
- Latency: the input is stable from rising edge E1 (first edge that samples it). The level and pulse change at edge E(STABLE_CYC+2), so they are visible in the cycle after that edge.
- With STABLE_CYC=1, the level follows s2 with one cycle of latency.
- Pulse width is always exactly 1 cycle. There is no combinational path from any input to any output.

## Test plan
Parameters for all scenarios: BTN_N=4, SW_N=8, STABLE_CYC=4, REPEAT_DLY=10, REPEAT_PER=3.
- Reset with button=4'b0001 held:
  - all outputs are 0 during reset.
  - After release, btn_level[0] rises at the 6th edge and btn_press[0] is high for exactly 1 cycle. Other bits stay quiet.
- Bounce on button[1]:
  - Stimulus: 1,0,1,1,0, then steady 1.
  - Required response: no pulse during the bounce; btn_press[1] comes 6 edges after the last 0→1.
- Steady 3-cycle glitch on SW[5]:
  - Required response: sw_level and sw_change stay 0.
  - With a 4-cycle glitch, sw_level[5] toggles and sw_change[5] pulses twice.
- Hold button[2] for 30 cycles after press, then release:
  - btn_repeat[2] pulses at press+10, +13, +16, +19, +22, +25, +28.
  - btn_release[2] pulses once, with no repeat at or after it.
- Simultaneous change: button=4'hF and SW=8'hA5 in the same cycle:
  - Required response: all 4 press pulses and sw_change=8'hA5 in the same cycle.
- Assert rst_n during the repeat phase of button[3]:
  - Required response: outputs drop to 0 asynchronously.
  - After deassert with the button still held, a fresh press comes after 6 edges.
